// File: rtl/packet_receiver.sv
// packet_receiver: 8N1 UART deserialiser that assembles PACKET_SIZE bytes
// (first byte most significant) into one word offered on a valid/ack
// handshake, with framing-error, inter-byte timeout and overrun reporting.
module packet_receiver #(
    parameter logic [15:0] PACKET_SIZE  = 16'd2,
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    output logic [PACKET_SIZE*8-1:0] packet,
    output logic                     valid,
    input  logic                     ack,
    output logic                     busy,
    output logic                     frame_err,
    output logic                     timeout,
    output logic                     overrun
);

    localparam int unsigned PW = 32'(PACKET_SIZE) * 32'd8;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    logic            rxd_meta;
    logic            rxd_sync;
    logic            prev;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_byte;
    logic            byte_strobe;
    logic [15:0]     count;
    logic [TW-1:0]   tcnt;
    logic [PW-1:0]   assembled;

    // Two-flop synchroniser plus edge register; prev resets low so a line
    // held low through reset must be seen high before a start bit counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            prev     <= 1'b0;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            prev     <= rxd_sync;
        end
    end

    // Bit-level FSM: start-bit qualification, mid-bit sampling, stop check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            rx_byte     <= '0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (prev && !rxd_sync)
                        state <= S_START;
                end
                S_START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        state   <= rxd_sync ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        rx_byte <= {rxd_sync, rx_byte[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                        if (rxd_sync)
                            byte_strobe <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Earlier bytes of the packet live in a shift register one byte short of
    // the packet width; a single-byte packet needs none.
    generate
        if (PACKET_SIZE > 16'd1) begin : g_shift
            logic [PW-9:0] shift_reg;
            // Shift each completed byte in at the low end
            always_ff @(posedge clk) begin
                if (rst)
                    shift_reg <= '0;
                else if (byte_strobe)
                    shift_reg <= assembled[PW-9:0];
            end
            assign assembled = {shift_reg, rx_byte};
        end else begin : g_noshift
            assign assembled = rx_byte;
        end
    endgenerate

    // Packet assembly, handshake, inter-byte timeout and overrun tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            tcnt    <= '0;
            packet  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (valid && ack)
                valid <= 1'b0;
            if (frame_err) begin
                count <= '0;
                tcnt  <= '0;
            end else if (byte_strobe) begin
                tcnt <= '0;
                if (count == PACKET_SIZE - 16'd1) begin
                    count <= '0;
                    // A load in the same cycle as ack keeps valid high
                    if (!valid || ack) begin
                        packet <= assembled;
                        valid  <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    count <= count + 16'd1;
                end
            end else if (count == 16'd0) begin
                tcnt <= '0;
            end else if (state == S_IDLE) begin
                if (tcnt == TO_M1) begin
                    timeout <= 1'b1;
                    count   <= '0;
                    tcnt    <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    assign busy = (state != S_IDLE) || (count != 16'd0);

endmodule

// File: tb/tb_packet_receiver.sv
// Directed testbench for packet_receiver with an 8N1 line driver.
module tb_packet_receiver;

    localparam int unsigned CPB = 4;
    localparam int unsigned TO  = 80;
    localparam logic [15:0] PS  = 16'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        ack;
    logic [15:0] packet;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic        timeout;
    logic        overrun;

    int vectors     = 0;
    int miscompares = 0;

    packet_receiver #(
        .PACKET_SIZE (PS),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .packet   (packet),
        .valid    (valid),
        .ack      (ack),
        .busy     (busy),
        .frame_err(frame_err),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One 8N1 frame, LSB first; returns at the end of the stop bit, line high.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; ack = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({packet, valid, busy, frame_err, timeout, overrun} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0",
                     {packet, valid, busy, frame_err, timeout, overrun});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({valid, busy, frame_err, timeout, overrun} !== 5'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %b expected 00000",
                     {valid, busy, frame_err, timeout, overrun});
        end
    endtask

    task automatic test_handshake();
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        @(negedge clk);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_latency_early: got %b expected 0", valid);
        end
        @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'hABCD) begin
            miscompares++;
            $display("FAIL packet_abcd: got valid=%b packet=%h expected valid=1 packet=abcd",
                     valid, packet);
        end
        vectors++;
        if ({frame_err, timeout, overrun} !== 3'b000) begin
            miscompares++;
            $display("FAIL flags_abcd: got %b expected 000", {frame_err, timeout, overrun});
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'hABCD) begin
            miscompares++;
            $display("FAIL valid_hold: got valid=%b packet=%h expected valid=1 packet=abcd",
                     valid, packet);
        end
        pulse_ack();
        vectors++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_clears: got valid=%b busy=%b expected 0 0", valid, busy);
        end
    endtask

    task automatic test_overrun();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'h1234) begin
            miscompares++;
            $display("FAIL packet_1234: got valid=%b packet=%h expected valid=1 packet=1234",
                     valid, packet);
        end
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'h1234 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_drop: got valid=%b packet=%h overrun=%b expected 1 1234 1",
                     valid, packet, overrun);
        end
        pulse_ack();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_ack: got valid=%b expected 0", valid);
        end
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'h9ABC || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL packet_9abc: got valid=%b packet=%h overrun=%b expected 1 9abc 1",
                     valid, packet, overrun);
        end
        pulse_ack();
    endtask

    task automatic test_frame_err();
        int pulses = 0;
        int first  = 0;
        int vseen  = 0;
        send_byte(8'h11, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (valid !== 1'b0) vseen++;
        end
        vectors++;
        if (pulses != 1 || first != 1) begin
            miscompares++;
            $display("FAIL frame_err_pulse: got %0d pulses first at %0d expected 1 pulse at 1",
                     pulses, first);
        end
        vectors++;
        if (vseen != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_err_state: got valid_cycles=%0d busy=%b expected 0 0",
                     vseen, busy);
        end
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'h2233) begin
            miscompares++;
            $display("FAIL packet_2233: got valid=%b packet=%h expected valid=1 packet=2233",
                     valid, packet);
        end
        pulse_ack();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first  = 0;
        logic busy_mid = 1'b0;
        send_byte(8'h44, 1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 70) busy_mid = busy;
        end
        vectors++;
        if (busy_mid !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_busy_mid: got %b expected 1", busy_mid);
        end
        // Strobe lands 1 clk after the stop bit ends; 80 idle clks later the pulse shows.
        vectors++;
        if (pulses != 1 || first < 81 || first > 83) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %0d pulses first at %0d expected 1 pulse at 81..83",
                     pulses, first);
        end
        vectors++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_after: got busy=%b valid=%b expected 0 0", busy, valid);
        end
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'h5566) begin
            miscompares++;
            $display("FAIL packet_5566: got valid=%b packet=%h expected valid=1 packet=5566",
                     valid, packet);
        end
    endtask

    task automatic test_glitch();
        logic seen_busy = 1'b0;
        int   errs      = 0;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        for (int k = 2; k <= CPB / 2 + 3; k++) begin
            @(negedge clk);
            if (busy === 1'b1) seen_busy = 1'b1;
            if (frame_err !== 1'b0 || timeout !== 1'b0) errs++;
        end
        vectors++;
        if (seen_busy !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy: got seen=%b final=%b expected seen=1 final=0",
                     seen_busy, busy);
        end
        repeat (20) begin
            @(negedge clk);
            if (frame_err !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) errs++;
        end
        vectors++;
        if (errs != 0 || valid !== 1'b1 || packet !== 16'h5566) begin
            miscompares++;
            $display("FAIL glitch_quiet: got errs=%0d valid=%b packet=%h expected 0 1 5566",
                     errs, valid, packet);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h12, 1'b1);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_state: got busy=%b valid=%b overrun=%b expected 1 1 1",
                     busy, valid, overrun);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({packet, valid, busy, frame_err, timeout, overrun} !== 21'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got %h expected 0",
                     {packet, valid, busy, frame_err, timeout, overrun});
        end
        repeat (60) @(negedge clk);
        vectors++;
        if ({valid, busy, frame_err, timeout, overrun} !== 5'd0) begin
            miscompares++;
            $display("FAIL post_mid_reset_idle: got %b expected 00000",
                     {valid, busy, frame_err, timeout, overrun});
        end
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (valid !== 1'b1 || packet !== 16'hDEAD || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL packet_dead: got valid=%b packet=%h overrun=%b expected 1 dead 0",
                     valid, packet, overrun);
        end
        pulse_ack();
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL dead_ack: got valid=%b expected 0", valid);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_overrun();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_receiver.md
# packet_receiver

Receive-side counterpart of `packet_sender`. It deserialises an 8N1 UART line and assembles PACKET_SIZE consecutive bytes into one packet word, where the first byte received is the most significant. It sits between the FTDI RX pin and downstream logic such as the FFT input buffer. It presents each packet with a valid/ack handshake and reports framing errors, inter-byte timeouts and overruns.

## Interface
- PACKET_SIZE, 16'd2, bytes per packet (≥1)
- CLKS_PER_BIT, 104, clk cycles per UART bit (≥4, even)
- TIMEOUT_CLKS, 20*CLKS_PER_BIT, max idle clks between bytes of one packet
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rxd  in  1  asynchronous UART line, idle high
- packet  out  PACKET_SIZE*8  assembled packet; byte 0 in bits [PACKET_SIZE*8-1 -: 8]
- valid  out  1  packet holds an unconsumed packet
- ack  in  1  consumer accepts packet; sampled only while valid=1
- busy  out  1  reception in progress (bit FSM not IDLE or partial packet held)
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- timeout  out  1  one-cycle pulse: partial packet discarded on inter-byte gap
- overrun  out  1  sticky: a completed packet was dropped because valid was still set

## Operation
- Input conditioning: 2-FF synchroniser on rxd, reset to 1. Edge register `prev` resets to 0, so a line held low through reset never starts a frame. The line must be seen high first.
- Bit FSM states:
  - IDLE: a falling edge of the synchronised line (prev=1, cur=0) → START.
  - START: wait CLKS_PER_BIT/2 clks, then sample. If high, treat as a glitch and go → IDLE. If low → DATA.
  - DATA: sample every CLKS_PER_BIT clks, 8 bits, LSB first. After bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT clks.
    - High: pulse internal byte_strobe for one cycle and go → IDLE.
    - Low: pulse frame_err, discard the partial packet (byte count←0), and go → IDLE. The next falling edge still requires a high sample first.
- Packet assembler:
  - On byte_strobe: shift register ← {shift[PACKET_SIZE*8-9:0], byte}; count←count+1.
  - When count reaches PACKET_SIZE:
    - If valid=0, or ack=1 in the same cycle: packet←assembled value, valid←1.
    - Otherwise: overrun←1, packet is not modified, and the new packet is dropped.
  - count←0 either way.
- Handshake: valid stays high until a cycle with ack=1. valid←0 on the next edge unless a new packet loads in that same cycle, in which case valid stays 1. ack is ignored while valid=0.
- Timeout:
  - The counter runs while 0<count<PACKET_SIZE and the bit FSM is in IDLE.
  - It clears on every byte_strobe and whenever count=0.
  - At TIMEOUT_CLKS: pulse timeout, set count←0, clear the counter.
- busy = (bit FSM ≠ IDLE) | (count ≠ 0).
- overrun is cleared only by rst.
- Reset (including mid-frame) drives the following to 0: bit FSM→IDLE, count, shift register, packet, valid, busy, frame_err, timeout, overrun, and all counters.

## Timing
- Let T be the first clk at which the synchronised line shows the start-bit low (2–3 clks after the pin falls).
- Sample points:
  - Start bit: T+CLKS_PER_BIT/2.
  - Data bit i: T+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit: T+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
- byte_strobe and frame_err assert in the cycle after the stop sample.
- valid rises 1 clk after the byte_strobe of the last byte. packet is stable in that same cycle.
- Back-to-back bytes with no idle gap are supported: the bit FSM is in IDLE again before the mid-point of the next start bit.
- Minimum ack-to-valid-low latency is 1 clk. A packet can be consumed every cycle.
- Accepted baud error: ±4 % (sampling near bit centre).

## Test plan
All scenarios use CLKS_PER_BIT=4, TIMEOUT_CLKS=80, PACKET_SIZE=2, and an 8N1 bus-functional model on rxd.
- Send 0xAB, 0xCD with ack held 0 → packet=16'hABCD, valid=1 and stays 1; frame_err=timeout=overrun=0. Pulse ack for 1 clk → valid=0 the next clk.
- Send 0x12 0x34 then 0x56 0x78 with ack=0 throughout → packet stays 16'h1234, overrun=1. Pulse ack, then send 0x9A 0xBC → packet=16'h9ABC.
- Send 0x11 with stop bit 0 → frame_err is a single 1-clk pulse, no valid, busy=0 after. Then send 0x22 0x33 → packet=16'h2233.
- Send 0x44, then idle rxd high for 100 clks → timeout pulse at 80 idle clks after the byte, busy=0. Then send 0x55 0x66 → packet=16'h5566.
- Drive a 1-clk low glitch on rxd → no byte_strobe, busy returns to 0 within CLKS_PER_BIT/2+3 clks, no error pulses.
- Assert rst for 1 clk in the middle of the 2nd byte (ack=0) → all outputs 0 on the next clk. A following full packet 0xDE 0xAD → packet=16'hDEAD, overrun=0.
